// File: rtl/phase_sequence_receiver_pkg.sv
// phase_sequence_receiver_pkg: state/error encodings and default phase lengths shared with the sequencer
package phase_sequence_receiver_pkg;
  typedef enum logic [2:0] {
    HUNT  = 3'd0,
    IDLE  = 3'd1,
    PRE   = 3'd2,
    DATA  = 3'd3,
    TRAIL = 3'd4,
    END   = 3'd5
  } state_e;
  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_PRE   = 2'd1;
  localparam logic [1:0] ERR_DATA  = 2'd2;
  localparam logic [1:0] ERR_TRAIL = 2'd3;
  localparam int T1_DEF = 3;
  localparam int T2_DEF = 5;
  localparam int T3_DEF = 7;
endpackage

// File: rtl/phase_sequence_receiver.sv
// phase_sequence_receiver: decodes one bit per timed preamble/data/trailer frame on din; ports clk, reset, din -> data_bit, data_valid, frame_err, err_code, frame_count, state_dbg (all registered)
module phase_sequence_receiver
  import phase_sequence_receiver_pkg::*;
#(
  parameter int T1_LEN = T1_DEF,
  parameter int T2_LEN = T2_DEF,
  parameter int T3_LEN = T3_DEF,
  parameter int CNT_W  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       din,
  output logic       data_bit,
  output logic       data_valid,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic [7:0] frame_count,
  output logic [2:0] state_dbg
);
  localparam logic [CNT_W-1:0] T1_LAST = CNT_W'(T1_LEN - 1);
  localparam logic [CNT_W-1:0] T2_LAST = CNT_W'(T2_LEN - 1);
  localparam logic [CNT_W-1:0] T3_LAST = CNT_W'(T3_LEN - 1);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             data_q, data_d;
  logic             valid_d;
  logic [1:0]       err_d;
  logic             data_bit_q, data_valid_q, frame_err_q;
  logic [1:0]       err_code_q;
  logic [7:0]       frame_count_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = ERR_NONE;
    case (state_q)
      HUNT: state_d = din ? HUNT : IDLE;
      IDLE: if (din) begin
        state_d = PRE;
        cnt_d   = CNT_W'(1);
      end
      PRE: if (!din) begin
        err_d   = ERR_PRE;
        state_d = HUNT;
      end else if (cnt_q == T1_LAST) begin
        state_d = DATA;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 1'b1;
      DATA: if (cnt_q != '0 && din != data_q) begin
        err_d   = ERR_DATA;
        state_d = HUNT;
      end else begin
        data_d = (cnt_q == '0) ? din : data_q;
        if (cnt_q == T2_LAST) begin
          state_d = TRAIL;
          cnt_d   = '0;
        end else cnt_d = cnt_q + 1'b1;
      end
      TRAIL: if (!din) begin
        err_d   = ERR_TRAIL;
        state_d = HUNT;
      end else if (cnt_q == T3_LAST) state_d = END;
      else cnt_d = cnt_q + 1'b1;
      END: if (!din) begin
        valid_d = 1'b1;
        state_d = IDLE;
      end else begin
        err_d   = ERR_TRAIL;
        state_d = HUNT;
      end
      default: state_d = HUNT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= HUNT;
      cnt_q         <= '0;
      data_q        <= 1'b0;
      data_bit_q    <= 1'b0;
      data_valid_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      err_code_q    <= ERR_NONE;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      data_q        <= data_d;
      data_bit_q    <= valid_d & data_q;
      data_valid_q  <= valid_d;
      frame_err_q   <= err_d != ERR_NONE;
      err_code_q    <= err_d;
      frame_count_q <= valid_d ? frame_count_q + 8'd1 : frame_count_q;
    end
  end
  assign data_bit    = data_bit_q;
  assign data_valid  = data_valid_q;
  assign frame_err   = frame_err_q;
  assign err_code    = err_code_q;
  assign frame_count = frame_count_q;
  assign state_dbg   = state_q;
endmodule

// File: tb/tb_phase_sequence_receiver.sv
// tb_phase_sequence_receiver: directed frames with hand-computed expectations for phase_sequence_receiver
module tb_phase_sequence_receiver;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       din = 1'b0;
  logic       data_bit, data_valid, frame_err;
  logic [1:0] err_code;
  logic [7:0] frame_count;
  logic [2:0] state_dbg;
  int n_chk = 0, n_fail = 0;
  int cyc = 0, n_valid = 0, n_err = 0, n_bad_code = 0, last_cyc = 0;
  phase_sequence_receiver dut (
    .clk(clk), .reset(reset), .din(din), .data_bit(data_bit), .data_valid(data_valid),
    .frame_err(frame_err), .err_code(err_code), .frame_count(frame_count), .state_dbg(state_dbg)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step(input logic v);
    din = v;
    @(posedge clk);
    #1;
    cyc++;
    if (frame_err) n_err++;
    if (!frame_err && err_code != 2'd0) n_bad_code++;
    if (data_valid) begin
      n_valid++;
      last_cyc = cyc;
    end
  endtask
  task automatic frame(input logic b);
    repeat (3) step(1'b1);
    repeat (5) step(b);
    repeat (7) step(1'b1);
    step(1'b0);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    step(1'b0);
    reset = 1'b0;
  endtask
  initial begin
    int e0, v0, c0;
    logic [3:0] bits;
    reset = 1'b1;
    step(1'b0);
    step(1'b0);
    check("rst_state", state_dbg, 0);
    check("rst_valid", data_valid, 0);
    check("rst_err", frame_err, 0);
    check("rst_code", err_code, 0);
    check("rst_count", frame_count, 0);
    check("rst_bit", data_bit, 0);
    reset = 1'b0;
    step(1'b0);
    check("hunt_to_idle", state_dbg, 1);
    step(1'b0);
    n_err = 0;
    n_valid = 0;
    frame(1'b1);
    check("f1_valid", data_valid, 1);
    check("f1_bit", data_bit, 1);
    check("f1_count", frame_count, 1);
    check("f1_no_err", n_err, 0);
    check("f1_state", state_dbg, 1);
    step(1'b0);
    check("f1_pulse_end", data_valid, 0);
    frame(1'b0);
    check("f0_valid", data_valid, 1);
    check("f0_bit", data_bit, 0);
    check("f0_count", frame_count, 2);
    do_reset();
    step(1'b0);
    n_valid = 0;
    bits = 4'b1001;
    c0 = 0;
    for (int i = 0; i < 4; i++) begin
      frame(bits[3-i]);
      check("b2b_valid", data_valid, 1);
      check("b2b_bit", data_bit, bits[3-i]);
      if (i > 0) check("b2b_period", last_cyc - c0, 16);
      c0 = last_cyc;
    end
    check("b2b_pulses", n_valid, 4);
    check("b2b_count", frame_count, 4);
    v0 = n_valid;
    step(1'b1);
    step(1'b1);
    step(1'b0);
    check("pre_err", frame_err, 1);
    check("pre_code", err_code, 1);
    check("pre_no_valid", data_valid, 0);
    step(1'b0);
    check("pre_err_pulse", frame_err, 0);
    check("pre_code_clr", err_code, 0);
    check("pre_resync", state_dbg, 1);
    frame(1'b1);
    check("pre_next_valid", data_valid, 1);
    check("pre_next_count", frame_count, 5);
    check("pre_valid_cnt", n_valid - v0, 1);
    repeat (3) step(1'b1);
    step(1'b0);
    step(1'b0);
    step(1'b1);
    check("data_err", frame_err, 1);
    check("data_code", err_code, 2);
    step(1'b0);
    step(1'b0);
    v0 = n_valid;
    repeat (3) step(1'b1);
    repeat (5) step(1'b1);
    repeat (8) step(1'b1);
    check("trail_long_err", frame_err, 1);
    check("trail_long_code", err_code, 3);
    check("trail_long_no_valid", n_valid - v0, 0);
    check("trail_long_count", frame_count, 5);
    step(1'b0);
    repeat (3) step(1'b1);
    repeat (5) step(1'b0);
    repeat (3) step(1'b1);
    step(1'b0);
    check("trail_short_code", err_code, 3);
    check("trail_short_count", frame_count, 5);
    step(1'b0);
    repeat (3) step(1'b1);
    repeat (2) step(1'b1);
    e0 = n_err;
    v0 = n_valid;
    reset = 1'b1;
    step(1'b1);
    reset = 1'b0;
    repeat (11) step(1'b1);
    check("midrst_count", frame_count, 0);
    check("midrst_state", state_dbg, 0);
    check("midrst_no_err", n_err - e0, 0);
    check("midrst_no_valid", n_valid - v0, 0);
    step(1'b0);
    frame(1'b1);
    check("midrst_next_valid", data_valid, 1);
    check("midrst_next_count", frame_count, 1);
    for (int i = 0; i < 254; i++) frame(i[0]);
    check("wrap_255", frame_count, 255);
    frame(1'b0);
    check("wrap_0", frame_count, 0);
    check("wrap_valid", data_valid, 1);
    check("code_zero_without_err", n_bad_code, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
